// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divider, FSM encoding, frame size.
// Used by the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;

  function automatic int baud_div(
    input int clock_hz,
    input int baud_rate
  );
    return clock_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side write port of the UART transmitter.
// Master drives bytes in; slave reports FIFO and line status.
interface uart_tx_if;

  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       overflow;
  logic       busy;

  modport master (
    output wr_data,
    output wr_en,
    input  full,
    input  overflow,
    input  busy
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    output full,
    output overflow,
    output busy
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrap-around pointers.
// Sized by DEPTH_LOG2; full and empty come straight off the pointers.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wp;
  logic [DEPTH_LOG2:0] rp;

  assign empty = (wp == rp);
  assign full  = (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]) &&
                 (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0]);
  assign dout  = mem[rp[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[DEPTH_LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser.
// Frames run back-to-back while the FIFO has data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_tx_if.slave  wr,
  output logic      tx
);

  localparam int DIV = baud_div(CLOCK_HZ, BAUD_RATE);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  tx_state_t      state;
  logic [CW-1:0]  cnt;
  logic [7:0]     shift_reg;
  logic [2:0]     bit_idx;
  logic [7:0]     head;
  logic           empty;
  logic           tick;
  logic           pop;

  assign tick = (cnt == LAST);

  always_comb begin
    pop = 1'b0;
    if (!empty)
      pop = (state == IDLE) || (state == STOP && tick);
  end

  uart_tx_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (8)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (wr.wr_en),
    .pop  (pop),
    .din  (wr.wr_data),
    .dout (head),
    .full (wr.full),
    .empty(empty)
  );

  assign wr.busy = (state != IDLE) || !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shift_reg   <= '0;
      bit_idx     <= '0;
      tx          <= 1'b1;
      wr.overflow <= 1'b0;
    end else begin
      wr.overflow <= wr.wr_en && wr.full;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            shift_reg <= head;
            tx        <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            tx      <= shift_reg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (!empty) begin
              shift_reg <= head;
              tx        <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed writes, scoreboard of expected bytes,
// and a line monitor that decodes every frame seen on tx.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DIV   = 434;
  localparam int FRAME = 4340;

  logic clk = 1'b0;
  logic rst_n;
  logic tx;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] sb[$];
  int         starts[$];

  uart_tx_if u_if ();

  uart_tx u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wr   (u_if),
    .tx   (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    @(negedge clk);
    u_if.wr_en   = 1'b1;
    u_if.wr_data = b;
    @(negedge clk);
    u_if.wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int lim, output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (u_if.busy && n < lim);
    chk_eq("idle_timeout", u_if.busy, 0);
    t = cyc;
  endtask

  initial begin : monitor
    logic [9:0] got;
    logic [7:0] exp;
    bit         bad;
    bit         abort;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        starts.push_back(cyc);
        got   = '0;
        bad   = 1'b0;
        abort = 1'b0;
        for (int b = 0; b < FRAME_BITS && !abort; b++) begin
          for (int j = 0; j < DIV; j++) begin
            if (b != 0 || j != 0) @(negedge clk);
            if (!rst_n) begin
              abort = 1'b1;
              break;
            end
            if (j == 0) got[b] = tx;
            else if (tx !== got[b]) bad = 1'b1;
          end
        end
        if (!abort) begin
          chk_eq("frame_shape", {bad, got[0], got[9]}, 3'b001);
          chk_eq("frame_pending", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk_eq("frame_data", got[8:1], exp);
          end
        end
      end
    end
  end

  initial begin : stim
    int  n0, n1, wc, t;
    bit  bad;
    rst_n        = 1'b0;
    u_if.wr_en   = 1'b0;
    u_if.wr_data = 8'h00;

    // 1: reset
    repeat (5) @(negedge clk);
    chk_eq("rst_tx", tx, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rst_busy", u_if.busy, 0);
    chk_eq("rst_full", u_if.full, 0);
    chk_eq("rst_ovf", u_if.overflow, 0);
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    chk_eq("idle_tx_high", bad, 0);
    chk_eq("idle_no_frame", starts.size(), 0);

    // 2: single byte 0xAA
    n0 = starts.size();
    sb.push_back(8'hAA);
    wr_byte(8'hAA);
    wc = cyc;
    chk_eq("busy_on_write", u_if.busy, 1);
    wait_idle(FRAME + 50, t);
    chk_eq("single_frames", starts.size(), n0 + 1);
    chk_eq("latency", starts[n0] - wc, 1);
    chk_eq("busy_len", t - starts[n0], FRAME);

    // 3: back-to-back 0x55, 0x0F, 0xF0
    n0 = starts.size();
    sb.push_back(8'h55);
    sb.push_back(8'h0F);
    sb.push_back(8'hF0);
    @(negedge clk);
    u_if.wr_en   = 1'b1;
    u_if.wr_data = 8'h55;
    @(negedge clk);
    u_if.wr_data = 8'h0F;
    @(negedge clk);
    u_if.wr_data = 8'hF0;
    @(negedge clk);
    u_if.wr_en   = 1'b0;
    wait_idle(3 * FRAME + 50, t);
    chk_eq("b2b_frames", starts.size(), n0 + 3);
    chk_eq("b2b_gap1", starts[n0+1] - starts[n0], FRAME);
    chk_eq("b2b_gap2", starts[n0+2] - starts[n0+1], FRAME);
    chk_eq("b2b_total", t - starts[n0], 3 * FRAME);

    // 4: full / overflow while a frame is running
    n0 = starts.size();
    sb.push_back(8'h3C);
    wr_byte(8'h3C);
    repeat (3) @(negedge clk);
    chk_eq("active_busy", u_if.busy, 1);
    for (int i = 1; i <= 4; i++) sb.push_back(8'(i));
    u_if.wr_en   = 1'b1;
    u_if.wr_data = 8'h01;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) chk_eq("not_full_3", u_if.full, 0);
      if (i == 5) begin
        chk_eq("full_after_4", u_if.full, 1);
        chk_eq("no_ovf_yet", u_if.overflow, 0);
      end
      u_if.wr_data = 8'(i);
    end
    @(negedge clk);
    u_if.wr_en = 1'b0;
    chk_eq("ovf_pulse", u_if.overflow, 1);
    @(negedge clk);
    chk_eq("ovf_clear", u_if.overflow, 0);
    wait_idle(6 * FRAME, t);
    chk_eq("ovf_frames", starts.size(), n0 + 5);
    chk_eq("ovf_sb_empty", sb.size(), 0);

    // 5: reset mid-frame
    n0 = starts.size();
    sb.push_back(8'hC3);
    wr_byte(8'hC3);
    @(negedge clk);
    chk_eq("c3_started", starts.size(), n0 + 1);
    if (starts.size() > n0) begin
      while (cyc < starts[n0] + 2000) @(negedge clk);
      chk_eq("pre_rst_tx", tx, 0);
    end
    #3 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_tx", tx, 1);
    chk_eq("mid_rst_busy", u_if.busy, 0);
    chk_eq("mid_rst_full", u_if.full, 0);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b1;
    sb.delete();
    n1 = starts.size();
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) bad = 1'b1;
    end
    chk_eq("post_rst_tx", bad, 0);
    chk_eq("post_rst_frames", starts.size(), n1);

    // 6: loopback 0x00, 0xFF, 0xA5
    n0 = starts.size();
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    sb.push_back(8'hA5);
    wr_byte(8'h00);
    wr_byte(8'hFF);
    wr_byte(8'hA5);
    wait_idle(3 * FRAME + 50, t);
    chk_eq("loop_frames", starts.size(), n0 + 3);
    chk_eq("loop_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter. It is the outgoing counterpart of the computer's serial receive path.
- The CPU I/O side writes bytes into a small internal FIFO.
- The block serialises each byte onto `tx`, LSB first, at a fixed baud rate derived from the system clock.
- It sits beside the existing UART receiver in the top-level computer and drives the board `tx` pin.

Parameters:
- CLOCK_HZ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- DEPTH_LOG2, 2: FIFO depth is 2**DEPTH_LOG2 entries (4 by default).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous reset, active low.
- wr_data  in  8  byte to transmit.
- wr_en  in  1  write strobe; samples `wr_data` on the clock edge.
- full  out  1  FIFO holds 2**DEPTH_LOG2 bytes; writes are dropped.
- overflow  out  1  one-cycle pulse when `wr_en` arrives while `full` is high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- tx  out  1  serial line, idle high; registered output.

Behaviour:
- Reset (async, rst_n=0):
  - `tx`=1, `busy`=0, `full`=0, `overflow`=0.
  - FIFO emptied, FSM forced to IDLE, baud counter=0.
  - A reset mid-frame truncates the frame immediately. No partial byte is resumed.
- Bit timing:
  - DIV = floor(CLOCK_HZ/BAUD_RATE), which is 434 at the defaults.
  - Baud counter width is clog2(DIV); it counts 0..DIV-1.
  - Every line bit lasts exactly DIV clocks.
- FIFO:
  - Write accepted on an edge when `wr_en`=1 and `full`=0.
  - `full` is registered and authoritative. A write on the same edge as a pop while `full`=1 is dropped and `overflow` pulses.
  - Pointers are DEPTH_LOG2+1 bits with wrap-around.
  - Data leaves in write order.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. On an edge where the FIFO is non-empty: pop the head into shift_reg, clear the counter, `tx`<=0, go to START.
  - START: hold `tx`=0 for DIV clocks. Then `tx`<=shift_reg[0], bit_idx=0, go to DATA.
  - DATA: after each DIV clocks, shift right and increment bit_idx. After bit_idx 7 has been held DIV clocks, `tx`<=1 and go to STOP.
  - STOP: hold `tx`=1 for DIV clocks. At the end:
    - if the FIFO is non-empty, pop and go directly to START with `tx`<=0, so frames are back-to-back with no extra idle;
    - otherwise go to IDLE.
- Latency: a write at edge k into an empty FIFO while IDLE gives `tx` falling at edge k+1.
- Frame length: exactly 10*DIV clocks from the start edge to the end of the stop bit.
- `busy` = (state != IDLE) || FIFO non-empty, as combinational OR of registered terms.
- `wr_en` with `full`=0 during an active frame only enqueues. The current frame is unaffected.

Decomposition:
- Shared package uart_pkg holds:
  - DIV computation (function of CLOCK_HZ, BAUD_RATE);
  - FSM state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - the FRAME_BITS=10 constant, which the receiver also uses.
- One natural sub-module: uart_tx_fifo. It is a synchronous FIFO with push/pop/full/empty, parameterised by DEPTH_LOG2 and width 8, and is reusable by the receiver later.

Test Plan:
1. Reset check: hold rst_n=0 for 5 clocks, release -> `tx`=1, `busy`=0, `full`=0. `tx` stays 1 for 1000 clocks with no writes.
2. Single byte: write 0xAA -> `tx` low 434 clocks, then 0,1,0,1,0,1,0,1 at 434 clocks each, then 1 for 434 clocks. `busy` falls 4340 clocks after the start edge.
3. Back-to-back: write 0x55, 0x0F, 0xF0 on consecutive cycles -> three frames, no idle gap between stop and next start, total 13020 clocks.
4. Full/overflow: while a frame is active, write 5 bytes 0x01..0x05 on consecutive cycles.
   - `full` rises after the 4th.
   - The 5th write pulses `overflow` and is dropped.
   - Only 0x01..0x04 appear on the line.
5. Reset mid-frame: write 0xC3, assert rst_n=0 at start_edge+2000 -> `tx`=1 immediately and FIFO empty. After release `tx` stays 1 and no residual frame appears.
6. Loopback: connect `tx` to the existing receiver and send 0x00, 0xFF, 0xA5 -> receiver reports the same three bytes in order.
